// File: rtl/pll_seq_pkg.sv
// PLL reset sequencer shared types and helpers.
// State encoding plus constant functions for sizing.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single async input.
// Clears to 0 on reset so an unknown input reads as low.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async level through two flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer owning the derived system reset.
// Runs on the board oscillator; retries and re-sequences on loss of lock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT_CYCLES  = 65536,
  parameter int RELEASE_DELAY_CYCLES = 16,
  parameter int MAX_RETRIES          = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count
);

  localparam int MAXC = max2(
    max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
    max2(LOCK_TIMEOUT_CYCLES, RELEASE_DELAY_CYCLES));
  localparam int CNT_W = clog2(MAXC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST =
    CNT_W'(RELEASE_DELAY_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             pll_rst_q;
  logic             sys_reset_q;
  logic             ready_q;
  logic             fail_q;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // Next state, retry and loss-of-lock bookkeeping.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lol_d   = lol_q;
    if (force_relock) begin
      state_d = PLL_RESET;
      retry_d = '0;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_MAX) ? FAIL : PLL_RESET;
          end
        end
        STABLE: begin
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = RELEASE;
        end
        RELEASE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == REL_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = PLL_RESET;
            if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: state_d = PLL_RESET;
      endcase
    end
  end

  // Phase counter restarts on any state change; idles in RUN and FAIL.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (force_relock || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == RUN) || (state_q == FAIL)) begin
      cnt_d = cnt_q;
    end
  end

  // State, counters and outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      lol_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lol_q       <= lol_d;
      pll_rst_q   <= (state_d == PLL_RESET) || (state_d == FAIL);
      sys_reset_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign lol_count   = lol_q;

endmodule
